data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory responder for the mem stage's load/store requests.
//   Accepts one request at a time and returns read data or a write acknowledge after LATENCY cycles.
//   Drives stall_m to the hazard unit so the pipeline holds while an access is outstanding.
//   Contains a word-addressed synchronous RAM array of DEPTH_WORDS 32-bit words.
// PARAMETERS
//   ADDR_W       10    word-index width; DEPTH_WORDS = 2**ADDR_W
//   DEPTH_WORDS  1024  number of 32-bit words in the array
//   LATENCY      3     cycles from accept to resp_valid; legal range 1..15
// PORTS
//   clock           in   1   single clock, rising edge
//   reset           in   1   synchronous, active-high
//   req_valid       in   1   mem stage presents a request
//   req_write       in   1   1 = store, 0 = load
//   req_addr        in   32  byte address (ALUOutM)
//   req_wdata       in   32  store data (WriteDataM)
//   req_ready       out  1   responder can accept a request this cycle
//   resp_valid      out  1   one-cycle pulse: access complete
//   resp_rdata      out  32  load data; valid when resp_valid && !write
//   stall_m         out  1   to hazard unit: hold the pipeline
//   misaligned_err  out  1   sticky: a request with req_addr[1:0] != 0 was accepted
// BEHAVIOUR
//   Reset state: req_ready=0, resp_valid=0, resp_rdata=0, stall_m=0, misaligned_err=0 while reset is high.
//     The FSM resets to IDLE. RAM contents are NOT cleared.
//   FSM states and outputs:
//     IDLE  req_ready=1; stall_m=req_valid
//     WAIT  req_ready=0; stall_m=1
//     RESP  req_ready=0; stall_m=0; resp_valid=1
//   Transitions:
//     IDLE->RESP if accept && LATENCY==1; IDLE->WAIT if accept && LATENCY>1.
//     Accept = req_valid && req_ready. On accept, latch write, word index, wdata, and cnt=LATENCY-2.
//     WAIT: if cnt==0 -> RESP, else cnt--.
//     RESP -> IDLE unconditionally, always after exactly one cycle.
//   Latency: accept on edge T -> resp_valid high in cycle T+LATENCY.
//     Back-to-back requests: next accept no earlier than T+LATENCY+1.
//   Access commit: performed on the edge entering RESP, using the latched values.
//     Store writes the RAM on that edge.
//     Load captures RAM[idx] into resp_rdata on that edge.
//     For a store, resp_rdata is set to 0.
//     resp_rdata holds its value until the next response.
//   Address: idx = req_addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
//   Misaligned request: still accepted and serviced at the aligned word; misaligned_err sets and stays
//     set until reset.
//   Request inputs during WAIT/RESP are ignored and not latched. The requester holds them stable while stall_m=1.
//   Load after store to the same word returns the newly stored data; there is no stale read.
//   Reset mid-operation (WAIT or RESP) aborts the access: a pending store is NOT committed and no resp_valid is issued.
//   cnt is 4 bits wide; LATENCY outside 1..15 is a configuration error (elaboration check).
// TESTING
//   1. Store 0xDEADBEEF to addr 0x10, LATENCY=3 -> stall_m high for 3 cycles; resp_valid at T+3; req_ready back at T+4.
//   2. Load from 0x10 after test 1 -> resp_rdata=0xDEADBEEF at T+3; a store-ack resp shows resp_rdata=0.
//   3. Store 0x12345678 to addr 0x1010 (DEPTH 1024), then load 0x0010 -> wrap-around returns 0x12345678.
//   4. Load at 0x13 -> serviced as word 0x10; misaligned_err=1 and stays 1 through later requests until reset.
//   5. Store to 0x20 with reset asserted during WAIT -> resp_valid never pulses; a later load from 0x20 returns the old value.
//   6. LATENCY=1 build; hold req_valid high with alternating addresses -> accept every 2 cycles;
//      resp_valid each odd cycle; stall_m low in RESP.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Request/response bundle between the mem stage and the
//                data-memory responder, plus the hazard-unit stall line.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall_m;
    logic        misaligned_err;

    // Mem stage side: issues requests, observes completion and stall
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, stall_m, misaligned_err
    );

    // Responder side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, stall_m, misaligned_err
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module      : data_mem_responder
//  Description : Multi-cycle word-addressed data RAM for the mem stage.
//                One request at a time; response LATENCY cycles after accept.
//                Holds the pipeline (stall_m) while an access is outstanding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 2 ** ADDR_W,
    parameter int LATENCY     = 3
) (
    input wire               clock,
    input wire               reset,
    data_mem_responder_if.slave bus
);

    // Configuration sanity: counter is 4 bits, array must match index width
    if (LATENCY < 1 || LATENCY > 15) begin : g_latencyCheck
        $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS != 2 ** ADDR_W) begin : g_depthCheck
        $error("data_mem_responder: DEPTH_WORDS must equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit         c_single  = (LATENCY == 1);
    localparam logic [3:0] c_cntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_misErr;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_commit;
    logic                w_cWrite;
    logic [ADDR_W-1:0]   w_cIdx;
    logic [31:0]         w_cWdata;
    logic                w_unusedAddrBits;

    // Address bits above the word index only wrap the address space
    assign w_unusedAddrBits = ^bus.req_addr[31:ADDR_W+2];

    assign w_accept = (r_state == S_IDLE) && bus.req_valid && !reset;

    // With LATENCY==1 the commit edge is the accept edge, so the request
    // itself is used; otherwise the latched copy is used
    assign w_cWrite = c_single ? bus.req_write            : r_write;
    assign w_cIdx   = c_single ? bus.req_addr[ADDR_W+1:2] : r_idx;
    assign w_cWdata = c_single ? bus.req_wdata            : r_wdata;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, handshake outputs and commit strobe; all forced low in reset
    always_comb begin
        w_nextState     = r_state;
        w_commit        = 1'b0;
        bus.req_ready   = 1'b0;
        bus.stall_m     = 1'b0;
        bus.resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = !reset;
                bus.stall_m   = bus.req_valid && !reset;
                if (w_accept) begin
                    w_nextState = c_single ? S_RESP : S_WAIT;
                    w_commit    = c_single;
                end
            end
            S_WAIT: begin
                bus.stall_m = !reset;
                if (r_cnt == 4'd0) begin
                    w_nextState = S_RESP;
                    w_commit    = !reset;
                end
            end
            S_RESP: begin
                bus.resp_valid = !reset;
                w_nextState    = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Request capture and wait-cycle countdown
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= c_cntInit;
            r_write <= bus.req_write;
            r_idx   <= bus.req_addr[ADDR_W+1:2];
            r_wdata <= bus.req_wdata;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // RAM array; contents survive reset
    always_ff @(posedge clock) begin
        if (w_commit && w_cWrite) begin
            r_mem[w_cIdx] <= w_cWdata;
        end
    end

    // Response data: load result, zero for store acks, held between responses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (w_commit) begin
            r_rdata <= w_cWrite ? 32'd0 : r_mem[w_cIdx];
        end
    end

    // Sticky flag for any accepted request not on a word boundary
    always_ff @(posedge clock) begin
        if (reset) begin
            r_misErr <= 1'b0;
        end else if (w_accept && bus.req_addr[1:0] != 2'b00) begin
            r_misErr <= 1'b1;
        end
    end

    assign bus.resp_rdata     = reset ? 32'd0 : r_rdata;
    assign bus.misaligned_err = r_misErr && !reset;

endmodule

`default_nettype wire
